// File: rtl/vid_fetch_pkg.sv
// Shared types and widths for the display line fetch path.
package vid_fetch_pkg;

    localparam int VID_ADDR_W = 16;
    localparam int VID_DATA_W = 16;

    typedef enum logic [2:0] {
        IDLE,
        LATCH,
        FETCH,
        WAIT_LAST,
        FLUSH
    } fetch_state_t;

endpackage

// File: rtl/line_fifo.sv
// First-word fall-through prefetch FIFO; pointers carry one extra wrap bit
// so full and empty are told apart without a separate flag.
module line_fifo #(
    parameter int DEPTH = 8,
    parameter int W     = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [W-1:0]             push_data,
    input  logic                     pop,
    input  logic                     flush,
    output logic [W-1:0]             head,
    output logic                     valid,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] DEPTH_C = DEPTH[PW:0];

    logic [W-1:0] mem [DEPTH];
    logic [PW:0]  wr_ptr, rd_ptr;
    logic         push_ok, pop_ok;

    assign count   = wr_ptr - rd_ptr;
    assign valid   = (count != '0);
    assign push_ok = push && (count != DEPTH_C);
    assign pop_ok  = pop && valid;
    // Head reads as zero when empty so the output is clean out of reset.
    assign head    = valid ? mem[rd_ptr[PW-1:0]] : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok && !flush) mem[wr_ptr[PW-1:0]] <= push_data;
    end

endmodule

// File: rtl/line_fetch_sequencer.sv
// Per-scanline fetch controller: walks one display row through a single
// scheduler client port, one read in flight, gated by prefetch FIFO credit.
module line_fetch_sequencer
    import vid_fetch_pkg::*;
#(
    parameter int FIFO_DEPTH     = 8,
    parameter int WORDS_PER_LINE = 40,
    parameter int LINE_STRIDE    = 40
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  line_start,
    input  logic [VID_ADDR_W-1:0] base_addr,
    input  logic [9:0]            scan_line,
    input  logic [9:0]            scroll_y,
    input  logic [5:0]            pan_x,
    output logic [VID_ADDR_W-1:0] mem_addr,
    output logic                  mem_read_req,
    input  logic                  mem_busy,
    input  logic                  mem_data_ready,
    input  logic [VID_DATA_W-1:0] mem_data,
    input  logic                  word_rd,
    output logic [VID_DATA_W-1:0] word_data,
    output logic                  word_valid,
    output logic                  line_done,
    output logic                  underrun
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam logic [5:0]            WPL6     = 6'(WORDS_PER_LINE);
    localparam logic [VID_ADDR_W-1:0] STRIDE_C = VID_ADDR_W'(LINE_STRIDE);
    localparam logic [PW+1:0]         DEPTH_C  = FIFO_DEPTH[PW+1:0];

    fetch_state_t state_q, state_d;

    logic [VID_ADDR_W-1:0] base_q, row_base_q, row_base_c;
    logic [9:0]            scan_q, scroll_q;
    logic [5:0]            pan_q, col_q, col0_c, col_next;
    logic [5:0]            issued_q;
    logic                  outstanding_q;
    logic [10:0]           row_sum;
    logic [PW:0]           fifo_count;
    logic [PW+1:0]         credit_used;
    logic                  can_issue, push, pop;

    // Row base and starting column come from the latched line parameters.
    assign row_sum    = {1'b0, scan_q} + {1'b0, scroll_q};
    assign row_base_c = base_q + {5'b0, row_sum} * STRIDE_C;
    assign col0_c     = (pan_q >= WPL6) ? 6'd0 : pan_q;
    assign col_next   = (col_q == WPL6 - 6'd1) ? 6'd0 : col_q + 6'd1;

    assign credit_used = {1'b0, fifo_count} + {{(PW+1){1'b0}}, outstanding_q};
    assign can_issue   = !mem_busy && !outstanding_q && (issued_q < WPL6)
                         && (credit_used < DEPTH_C);

    // Responses belonging to an aborted line never reach the FIFO.
    assign push = mem_data_ready && outstanding_q
                  && ((state_q == FETCH) || (state_q == WAIT_LAST));
    assign pop  = word_rd && word_valid;

    always_comb begin
        state_d      = state_q;
        mem_read_req = 1'b0;
        line_done    = 1'b0;
        case (state_q)
            IDLE: ;
            LATCH: state_d = FETCH;
            FETCH: begin
                mem_read_req = can_issue;
                if ((issued_q == WPL6) && outstanding_q) begin
                    // Last response can land on the first cycle after the last issue.
                    if (mem_data_ready) begin
                        state_d   = IDLE;
                        line_done = 1'b1;
                    end else begin
                        state_d = WAIT_LAST;
                    end
                end
            end
            WAIT_LAST: begin
                if (mem_data_ready) begin
                    state_d   = IDLE;
                    line_done = 1'b1;
                end
            end
            FLUSH: if (mem_data_ready) state_d = LATCH;
            default: state_d = IDLE;
        endcase
        // A new line overrides everything; a read still in flight must drain first.
        if (line_start) begin
            mem_read_req = 1'b0;
            line_done    = 1'b0;
            state_d      = (outstanding_q && !mem_data_ready) ? FLUSH : LATCH;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            base_q        <= '0;
            scan_q        <= '0;
            scroll_q      <= '0;
            pan_q         <= '0;
            row_base_q    <= '0;
            col_q         <= '0;
            issued_q      <= '0;
            outstanding_q <= 1'b0;
            mem_addr      <= '0;
            underrun      <= 1'b0;
        end else begin
            state_q <= state_d;

            if (line_start) begin
                base_q   <= base_addr;
                scan_q   <= scan_line;
                scroll_q <= scroll_y;
                pan_q    <= pan_x;
                issued_q <= '0;
            end else if (mem_read_req) begin
                issued_q <= issued_q + 6'd1;
            end

            if (mem_read_req)        outstanding_q <= 1'b1;
            else if (mem_data_ready) outstanding_q <= 1'b0;

            // mem_addr only moves after a response, so it holds for the whole read.
            if (state_q == LATCH) begin
                row_base_q <= row_base_c;
                col_q      <= col0_c;
                mem_addr   <= row_base_c + {10'b0, col0_c};
            end else if (push) begin
                col_q    <= col_next;
                mem_addr <= row_base_q + {10'b0, col_next};
            end

            if (line_start)                  underrun <= 1'b0;
            else if (word_rd && !word_valid) underrun <= 1'b1;
        end
    end

    line_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (VID_DATA_W)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data (mem_data),
        .pop       (pop),
        .flush     (line_start),
        .head      (word_data),
        .valid     (word_valid),
        .count     (fifo_count)
    );

endmodule

// File: tb/tb_line_fetch_sequencer.sv
// Bench for line_fetch_sequencer: per-cycle memory model and address/data
// scoreboards, a table of line parameter vectors, plus hand-built corner sequences.
module tb_line_fetch_sequencer;
    localparam int FIFO_DEPTH = 8;
    localparam int WPL        = 40;
    localparam int STRIDE     = 40;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        line_start = 1'b0;
    logic [15:0] base_addr = '0;
    logic [9:0]  scan_line = '0;
    logic [9:0]  scroll_y = '0;
    logic [5:0]  pan_x = '0;
    logic [15:0] mem_addr;
    logic        mem_read_req;
    logic        mem_busy = 1'b0;
    logic        mem_data_ready = 1'b0;
    logic [15:0] mem_data = '0;
    logic        word_rd = 1'b0;
    logic [15:0] word_data;
    logic        word_valid, line_done, underrun;

    always #5 clk = ~clk;

    line_fetch_sequencer #(
        .FIFO_DEPTH(FIFO_DEPTH), .WORDS_PER_LINE(WPL), .LINE_STRIDE(STRIDE)
    ) dut (
        .clk(clk), .rst_n(rst_n), .line_start(line_start), .base_addr(base_addr),
        .scan_line(scan_line), .scroll_y(scroll_y), .pan_x(pan_x),
        .mem_addr(mem_addr), .mem_read_req(mem_read_req), .mem_busy(mem_busy),
        .mem_data_ready(mem_data_ready), .mem_data(mem_data), .word_rd(word_rd),
        .word_data(word_data), .word_valid(word_valid), .line_done(line_done),
        .underrun(underrun)
    );

    typedef struct {
        logic [15:0] base;
        logic [9:0]  scan;
        logic [9:0]  scroll;
        logic [5:0]  pan;
        logic [15:0] first;
        logic [15:0] last;
    } vec_t;

    vec_t vecs[6];

    int checks = 0, errors = 0;
    int cyc = 0, start_cyc = 0;
    int n_req = 0, n_done = 0, first_req_cyc = -1;
    int lat = 1, busy_from = -1, busy_to = -1;
    bit pop_en = 0, force_rd = 0, start_req = 0;
    bit m_out = 0, m_discard = 0, exp_underrun = 0;
    int m_cnt = 0;
    logic [15:0] m_addr = '0;
    logic [15:0] exp_addr_q[$];
    logic [15:0] exp_data_q[$];
    logic [15:0] addr_log[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [15:0] log_at(int i);
        if (i < addr_log.size()) return addr_log[i];
        return 16'hxxxx;
    endfunction

    // Reference address sequence for one line, straight from the row/column formula.
    function automatic void load_line(logic [15:0] b, logic [9:0] s, logic [9:0] y, logic [5:0] p);
        int row, rb, c0;
        row = int'(s) + int'(y);
        rb  = (int'(b) + row * STRIDE) % 65536;
        c0  = (int'(p) >= WPL) ? 0 : int'(p);
        exp_addr_q.delete();
        for (int i = 0; i < WPL; i++) exp_addr_q.push_back(16'((rb + (c0 + i) % WPL) % 65536));
    endfunction

    task automatic step();
        bit out_pre;
        @(negedge clk);
        cyc++;
        mem_data_ready = 1'b0;
        if (m_cnt > 0) begin
            m_cnt--;
            if (m_cnt == 0) begin
                mem_data_ready = 1'b1;
                mem_data       = m_addr ^ 16'h5A5A;
            end
        end
        mem_busy   = (cyc >= busy_from) && (cyc <= busy_to);
        line_start = start_req;
        start_req  = 1'b0;
        word_rd    = force_rd || (pop_en && word_valid);
        force_rd   = 1'b0;
        #1;
        out_pre = m_out;
        check("word_valid", word_valid, exp_data_q.size() != 0);
        check("underrun", underrun, exp_underrun);
        if (line_start) exp_underrun = 1'b0;
        else if (word_rd && !word_valid) exp_underrun = 1'b1;

        if (mem_read_req) begin
            n_req++;
            if (first_req_cyc < 0) first_req_cyc = cyc;
            check("req_while_busy", mem_busy, 1'b0);
            check("req_in_flight", out_pre, 1'b0);
            check("req_expected", exp_addr_q.size() > 0, 1'b1);
            if (exp_addr_q.size() > 0) check("mem_addr", mem_addr, exp_addr_q.pop_front());
            addr_log.push_back(mem_addr);
        end
        if (word_rd && word_valid && !line_start) begin
            check("pop_expected", exp_data_q.size() > 0, 1'b1);
            if (exp_data_q.size() > 0) check("word_data", word_data, exp_data_q.pop_front());
        end
        if (mem_data_ready && out_pre) begin
            check("addr_stable", mem_addr, m_addr);
            if (!m_discard && !line_start) exp_data_q.push_back(m_addr ^ 16'h5A5A);
            m_out     = 1'b0;
            m_discard = 1'b0;
        end
        if (line_done) begin
            n_done++;
            check("done_on_last_push", mem_data_ready && out_pre && exp_addr_q.size() == 0, 1'b1);
        end
        if (mem_read_req) begin
            m_out  = 1'b1;
            m_addr = mem_addr;
            m_cnt  = lat;
        end
        if (line_start) begin
            exp_data_q.delete();
            if (m_out) m_discard = 1'b1;
            load_line(base_addr, scan_line, scroll_y, pan_x);
        end
    endtask

    task automatic start_line(input vec_t v);
        base_addr = v.base;
        scan_line = v.scan;
        scroll_y  = v.scroll;
        pan_x     = v.pan;
        start_req = 1'b1;
        n_req = 0;
        first_req_cyc = -1;
        addr_log.delete();
        step();
        start_cyc = cyc;
    endtask

    task automatic run_line(input int budget);
        int d0 = n_done;
        int k = 0;
        while (n_done == d0 && k < budget) begin
            step();
            k++;
        end
        check("line_done_seen", n_done - d0, 1);
    endtask

    task automatic wait_reqs(input int n);
        int k = 0;
        while (n_req < n && k < 200) begin
            step();
            k++;
        end
        check("reqs_reached", n_req, n);
    endtask

    task automatic drain();
        int k = 0;
        pop_en = 1'b1;
        while (exp_data_q.size() > 0 && k < 100) begin
            step();
            k++;
        end
        step();
        check("drained", word_valid, 1'b0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1);
    end

    initial begin
        vecs[0] = '{16'h1000, 10'd2,    10'd1,    6'd38, 16'h109E, 16'h109D};
        vecs[1] = '{16'h2000, 10'd0,    10'd0,    6'd63, 16'h2000, 16'h2027};
        vecs[2] = '{16'hFFF0, 10'd1000, 10'd1000, 6'd5,  16'h3875, 16'h3874};
        vecs[3] = '{16'h0100, 10'd5,    10'd0,    6'd39, 16'h01EF, 16'h01EE};
        vecs[4] = '{16'h0000, 10'd1023, 10'd1023, 6'd40, 16'h3FB0, 16'h3FD7};
        vecs[5] = '{16'hFFE0, 10'd0,    10'd0,    6'd0,  16'hFFE0, 16'h0007};

        step();
        step();
        check("rst_mem_addr", mem_addr, 16'h0);
        check("rst_req", mem_read_req, 1'b0);
        check("rst_word_data", word_data, 16'h0);
        check("rst_done", line_done, 1'b0);
        rst_n = 1'b1;
        step();

        // Table: full lines with a 1-cycle memory and a draining pixel pipe.
        for (int v = 0; v < 6; v++) begin
            pop_en = 1'b1;
            lat = 1;
            start_line(vecs[v]);
            run_line(300);
            check("first_req_latency", first_req_cyc - start_cyc, 2);
            check("req_count", n_req, WPL);
            check("first_addr", log_at(0), vecs[v].first);
            check("last_addr", log_at(WPL - 1), vecs[v].last);
            if (v == 0) begin
                check("second_addr", log_at(1), 16'h109F);
                check("row_wrap_addr", log_at(2), 16'h1078);
            end
            drain();
        end

        // Credit stall: nothing popped, requests stop at FIFO depth.
        pop_en = 1'b0;
        start_line(vecs[0]);
        repeat (60) step();
        check("stall_req_count", n_req, FIFO_DEPTH);
        check("stall_fifo_entries", exp_data_q.size(), FIFO_DEPTH);
        force_rd = 1'b1;
        step();
        repeat (20) step();
        check("stall_one_more", n_req, FIFO_DEPTH + 1);
        pop_en = 1'b1;
        run_line(300);
        check("stall_total", n_req, WPL);
        drain();

        // Busy for five cycles after LATCH.
        busy_from = cyc + 3;
        busy_to   = cyc + 7;
        start_line(vecs[2]);
        run_line(300);
        check("busy_first_req", first_req_cyc - start_cyc, 7);
        check("busy_req_count", n_req, WPL);
        busy_from = -1;
        busy_to   = -1;
        drain();

        // Abort with a slow read in flight.
        pop_en = 1'b0;
        lat = 6;
        start_line(vecs[3]);
        wait_reqs(4);
        check("abort_fifo_before", word_valid, 1'b1);
        lat = 1;
        start_line(vecs[0]);
        step();
        check("abort_flush", word_valid, 1'b0);
        pop_en = 1'b1;
        run_line(400);
        check("abort_restart_latency", first_req_cyc - start_cyc, 7);
        check("abort_req_count", n_req, WPL);
        check("abort_first_addr", log_at(0), vecs[0].first);
        drain();

        // Underrun: sticky across pops, cleared by the next line.
        pop_en = 1'b0;
        start_line(vecs[1]);
        force_rd = 1'b1;
        step();
        step();
        check("underrun_set", underrun, 1'b1);
        wait_reqs(5);
        pop_en = 1'b1;
        repeat (6) step();
        check("underrun_sticky", underrun, 1'b1);
        run_line(300);
        drain();
        start_line(vecs[4]);
        step();
        check("underrun_cleared", underrun, 1'b0);
        run_line(300);
        drain();

        // Asynchronous reset in the middle of a line.
        pop_en = 1'b0;
        start_line(vecs[5]);
        wait_reqs(3);
        check("pre_reset_valid", word_valid, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_req", mem_read_req, 1'b0);
        check("async_rst_addr", mem_addr, 16'h0);
        check("async_rst_valid", word_valid, 1'b0);
        check("async_rst_data", word_data, 16'h0);
        check("async_rst_done", line_done, 1'b0);
        check("async_rst_underrun", underrun, 1'b0);
        m_out = 1'b0;
        m_cnt = 0;
        m_discard = 1'b0;
        exp_underrun = 1'b0;
        exp_data_q.delete();
        exp_addr_q.delete();
        step();
        step();
        rst_n = 1'b1;
        step();
        pop_en = 1'b1;
        start_line(vecs[0]);
        run_line(300);
        check("post_reset_req_count", n_req, WPL);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
